// File: rtl/ring_checksum_responder_if.sv
// Ring slot bundle for ring_checksum_responder: the incoming slot plus the
// responder's replacement slot and its drive-enable.
interface ring_checksum_responder_if;
  logic [31:0] RingIn;
  logic [3:0]  SlotTypeIn;
  logic [3:0]  SrcDestIn;
  logic [31:0] rspRingOut;
  logic [3:0]  rspSlotTypeOut;
  logic [3:0]  rspSrcDestOut;
  logic        rspDriveRing;

  modport master (
    output RingIn, SlotTypeIn, SrcDestIn,
    input  rspRingOut, rspSlotTypeOut, rspSrcDestOut, rspDriveRing
  );

  modport slave (
    input  RingIn, SlotTypeIn, SrcDestIn,
    output rspRingOut, rspSlotTypeOut, rspSrcDestOut, rspDriveRing
  );
endinterface

// File: rtl/ring_checksum_responder.sv
// Ring responder: absorbs messages for whichCore, checksums their payload and
// replies with one payload word. Optional dropped-request counter: RSP_DROP_COUNT_EN.
module ring_checksum_responder (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [3:0]                   whichCore,
  ring_checksum_responder_if.slave     ring,
  output logic                         rspBusy
`ifdef RSP_DROP_COUNT_EN
  ,
  output logic [7:0]                   dropCount
`endif
);

  localparam logic [3:0] slotToken   = 4'd1;
  localparam logic [3:0] slotNull    = 4'd7;
  localparam logic [3:0] slotMessage = 4'd8;

  localparam logic [3:0] stIdle      = 4'd0;
  localparam logic [3:0] stRxPay     = 4'd1;
  localparam logic [3:0] stWaitToken = 4'd2;
  localparam logic [3:0] stWaitN     = 4'd3;
  localparam logic [3:0] stSendHdr   = 4'd4;
  localparam logic [3:0] stSendPay   = 4'd5;

  logic [3:0]  state;
  logic [3:0]  nextState;
  logic [5:0]  inLen;
  logic [31:0] sum;
  logic [3:0]  srcReg;
  logic [3:0]  typeReg;
  logic [7:0]  burst;

  logic [3:0]  hdrSrc;
  logic [3:0]  hdrType;
  logic [5:0]  hdrLen;
  logic        mine;
  logic        headerSeen;
  logic        accept;
  logic        tokenSeen;

  assign hdrSrc     = ring.RingIn[13:10];
  assign hdrType    = ring.RingIn[9:6];
  assign hdrLen     = ring.RingIn[5:0];
  assign mine       = (ring.SlotTypeIn == slotMessage) && (ring.SrcDestIn == whichCore);
  // inLen runs independently of state, so a header is recognised only between messages.
  assign headerSeen = mine && (inLen == 6'd0);
  assign accept     = headerSeen && (state == stIdle);
  assign tokenSeen  = (state == stWaitToken) && (ring.SlotTypeIn == slotToken);

  always_comb begin
    // NOTE: default first so every path assigns nextState and no latch is inferred.
    nextState = state;
    case (state)
      stIdle: begin
        if (accept) begin
          nextState = (hdrLen == 6'd0) ? stWaitToken : stRxPay;
        end
      end
      stRxPay: begin
        if (inLen == 6'd1) begin
          nextState = stWaitToken;
        end
      end
      stWaitToken: begin
        if (tokenSeen) begin
          nextState = (ring.RingIn[7:0] == 8'd0) ? stSendHdr : stWaitN;
        end
      end
      stWaitN: begin
        if (burst == 8'd1) begin
          nextState = stSendHdr;
        end
      end
      stSendHdr: nextState = stSendPay;
      stSendPay: nextState = stIdle;
      default:   nextState = stIdle;
    endcase
  end

  // NOTE: all registers are plain state (no memory arrays), so every one gets an async reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= stIdle;
      inLen   <= 6'd0;
      sum     <= 32'd0;
      srcReg  <= 4'd0;
      typeReg <= 4'd0;
      burst   <= 8'd0;
    end else begin
      // NOTE: non-blocking so every register samples this cycle's values together.
      state <= nextState;

      if (headerSeen) begin
        inLen <= hdrLen;
      end else if (inLen != 6'd0) begin
        inLen <= inLen - 6'd1;
      end

      // Accepted payload only ever arrives in rxPay; dropped payload never does.
      if (accept) begin
        sum     <= 32'd0;
        srcReg  <= hdrSrc;
        typeReg <= hdrType;
      end else if (state == stRxPay) begin
        sum <= sum + ring.RingIn;
      end

      if (tokenSeen) begin
        burst <= ring.RingIn[7:0];
      end else if (state == stWaitN) begin
        burst <= burst - 8'd1;
      end
    end
  end

`ifdef RSP_DROP_COUNT_EN
  logic dropHeader;

  assign dropHeader = headerSeen && (state != stIdle);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dropCount <= 8'd0;
    end else if (dropHeader && (dropCount != 8'hFF)) begin
      dropCount <= dropCount + 8'd1;
    end
  end
`endif

  // Output mux: our own reply slots win, then the token rewrite, then nulling.
  always_comb begin
    ring.rspRingOut     = ring.RingIn;
    ring.rspSlotTypeOut = ring.SlotTypeIn;
    ring.rspSrcDestOut  = ring.SrcDestIn;
    ring.rspDriveRing   = 1'b0;
    if (state == stSendHdr) begin
      ring.rspRingOut     = {18'b0, whichCore, typeReg, 6'd1};
      ring.rspSlotTypeOut = slotMessage;
      ring.rspSrcDestOut  = srcReg;
      ring.rspDriveRing   = 1'b1;
    end else if (state == stSendPay) begin
      ring.rspRingOut     = sum;
      ring.rspSlotTypeOut = slotMessage;
      ring.rspSrcDestOut  = srcReg;
      ring.rspDriveRing   = 1'b1;
    end else if (tokenSeen) begin
      ring.rspRingOut   = ring.RingIn + 32'd2;
      ring.rspDriveRing = 1'b1;
    end else if (mine) begin
      ring.rspSlotTypeOut = slotNull;
      ring.rspDriveRing   = 1'b1;
    end
  end

  assign rspBusy = (state != stIdle);

endmodule

// File: tb/tb_ring_checksum_responder.sv
// Self-checking bench for ring_checksum_responder: vector table, directed
// corner sequences and randomized messages against a transaction-level model.
module tb_ring_checksum_responder;

  localparam logic [3:0] tTok  = 4'd1;
  localparam logic [3:0] tNull = 4'd7;
  localparam logic [3:0] tMsg  = 4'd8;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] whichCore;
  logic       rspBusy;
`ifdef RSP_DROP_COUNT_EN
  logic [7:0] dropCount;
`endif

  ring_checksum_responder_if ring ();

  ring_checksum_responder dut (
    .clock     (clock),
    .reset     (reset),
    .whichCore (whichCore),
    .ring      (ring),
    .rspBusy   (rspBusy)
`ifdef RSP_DROP_COUNT_EN
    ,
    .dropCount (dropCount)
`endif
  );

  always #5 clock = ~clock;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    logic [3:0]  sd;
    logic [31:0] eD;
    logic [3:0]  eT;
    logic [3:0]  eSD;
    logic        eDrv;
    logic        eBusy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] hdr(input logic [3:0] src, input logic [3:0] typ,
                                      input logic [5:0] len);
    return {18'b0, src, typ, len};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One ring slot: drive at the falling edge, compare outputs 1ns later.
  task automatic slot(input string name, input logic [31:0] d, input logic [3:0] t,
                      input logic [3:0] sd, input logic [31:0] eD, input logic [3:0] eT,
                      input logic [3:0] eSD, input logic eDrv, input logic eBusy);
    @(negedge clock);
    ring.RingIn     = d;
    ring.SlotTypeIn = t;
    ring.SrcDestIn  = sd;
    #1;
    check(name, {22'b0, ring.rspRingOut, ring.rspSlotTypeOut, ring.rspSrcDestOut,
                 ring.rspDriveRing, rspBusy},
          {22'b0, eD, eT, eSD, eDrv, eBusy});
  endtask

  task automatic passSlot(input string name, input logic [31:0] d, input logic [3:0] t,
                          input logic [3:0] sd, input logic eBusy);
    slot(name, d, t, sd, d, t, sd, 1'b0, eBusy);
  endtask

  task automatic nullSlot(input string name, input logic [31:0] d, input logic eBusy);
    slot(name, d, tMsg, whichCore, d, tNull, whichCore, 1'b1, eBusy);
  endtask

  task automatic tokenSlot(input string name, input logic [31:0] d);
    slot(name, d, tTok, 4'd0, d + 32'd2, tTok, 4'd0, 1'b1, 1'b1);
  endtask

  task automatic replySlot(input string name, input logic [31:0] eD, input logic [3:0] dest);
    slot(name, $urandom, tNull, 4'd0, eD, tMsg, dest, 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state: passthrough, not busy.
    reset           = 1'b1;
    whichCore       = 4'd6;
    ring.RingIn     = 32'h0000_1234;
    ring.SlotTypeIn = tTok;
    ring.SrcDestIn  = 4'd0;
    #1;
    check("reset_outputs", {22'b0, ring.rspRingOut, ring.rspSlotTypeOut, ring.rspSrcDestOut,
                            ring.rspDriveRing, rspBusy},
          {22'b0, 32'h0000_1234, tTok, 4'd0, 1'b0, 1'b0});
`ifdef RSP_DROP_COUNT_EN
    check("reset_dropCount", {56'b0, dropCount}, 64'd0);
`endif
    @(negedge clock);
    reset = 1'b0;

    // Vector table: basic message, foreign message, zero-length message.
    vecs.push_back('{32'h0000_1234, tMsg, 4'd5, 32'h0000_1234, tMsg, 4'd5, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0D42, tMsg, 4'd6, 32'h0000_0D42, tNull, 4'd6, 1'b1, 1'b0});
    vecs.push_back('{32'h0000_0010, tMsg, 4'd6, 32'h0000_0010, tNull, 4'd6, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_0020, tMsg, 4'd6, 32'h0000_0020, tNull, 4'd6, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_0000, tTok, 4'd0, 32'h0000_0002, tTok, 4'd0, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_AAAA, tNull, 4'd0, 32'h0000_1941, tMsg, 4'd3, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_BBBB, tNull, 4'd0, 32'h0000_0030, tMsg, 4'd3, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_CCCC, tNull, 4'd0, 32'h0000_CCCC, tNull, 4'd0, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0A00, tMsg, 4'd6, 32'h0000_0A00, tNull, 4'd6, 1'b1, 1'b0});
    vecs.push_back('{32'h0000_0100, tTok, 4'd0, 32'h0000_0102, tTok, 4'd0, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_5555, tNull, 4'd0, 32'h0000_1A01, tMsg, 4'd2, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_6666, tNull, 4'd0, 32'h0000_0000, tMsg, 4'd2, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_7777, tTok, 4'd0, 32'h0000_7777, tTok, 4'd0, 1'b0, 1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      slot($sformatf("vec%0d", i), vecs[i].d, vecs[i].t, vecs[i].sd, vecs[i].eD,
           vecs[i].eT, vecs[i].eSD, vecs[i].eDrv, vecs[i].eBusy);
    end

    // Checksum wraparound and train count 3: header lands 4 slots after the Token.
    nullSlot("wrap_hdr", hdr(4'd1, 4'd3, 6'd2), 1'b0);
    nullSlot("wrap_p0", 32'hFFFF_FFFF, 1'b1);
    nullSlot("wrap_p1", 32'h0000_0002, 1'b1);
    tokenSlot("train3_token", 32'h0000_0003);
    passSlot("train3_gap0", 32'h0000_0111, tNull, 4'd0, 1'b1);
    passSlot("train3_gap1", 32'h0000_0222, tMsg, 4'd9, 1'b1);
    passSlot("train3_gap2", 32'h0000_0333, tNull, 4'd0, 1'b1);
    replySlot("train3_rhdr", hdr(4'd6, 4'd3, 6'd1), 4'd1);
    replySlot("wrap_sum", 32'h0000_0001, 4'd1);
    passSlot("wrap_idle", 32'h0000_0444, tNull, 4'd0, 1'b0);

    // Header during waitN is dropped; header in the sendPay slot is dropped too.
    nullSlot("drop_hdrA", hdr(4'd4, 4'd2, 6'd1), 1'b0);
    nullSlot("drop_payA", 32'h0000_0077, 1'b1);
    tokenSlot("drop_token", 32'h0000_0004);
    nullSlot("drop_hdrB", hdr(4'd9, 4'd1, 6'd2), 1'b1);
    nullSlot("drop_payB0", 32'h0000_1000, 1'b1);
    nullSlot("drop_payB1", 32'h0000_2000, 1'b1);
    passSlot("drop_gap", 32'h0000_0555, tNull, 4'd0, 1'b1);
    replySlot("drop_rhdr", hdr(4'd6, 4'd2, 6'd1), 4'd4);
    slot("drop_sendpay_override", hdr(4'd5, 4'd1, 6'd0), tMsg, 4'd6,
         32'h0000_0077, tMsg, 4'd4, 1'b1, 1'b1);
    passSlot("drop_after_idle", 32'h0000_0666, tNull, 4'd0, 1'b0);
`ifdef RSP_DROP_COUNT_EN
    check("dropCount_2", {56'b0, dropCount}, 64'd2);
`endif

    // Saturation: park in waitToken, then 256 zero-length headers all dropped.
    nullSlot("sat_hdr", hdr(4'd2, 4'd2, 6'd0), 1'b0);
    for (int i = 0; i < 256; i++) begin
      nullSlot($sformatf("sat_drop%0d", i), hdr(4'd3, 4'd3, 6'd0), 1'b1);
    end
`ifdef RSP_DROP_COUNT_EN
    check("dropCount_sat", {56'b0, dropCount}, 64'd255);
`endif
    tokenSlot("sat_token", 32'h0000_0000);
    replySlot("sat_rhdr", hdr(4'd6, 4'd2, 6'd1), 4'd2);
    replySlot("sat_sum", 32'h0000_0000, 4'd2);
    passSlot("sat_idle", 32'h0000_0777, tNull, 4'd0, 1'b0);

    // Reset pulsed during waitN abandons the reply.
    nullSlot("rst_hdr", hdr(4'd7, 4'd1, 6'd0), 1'b0);
    tokenSlot("rst_token", 32'h0000_000A);
    passSlot("rst_waitN", 32'h0000_0888, tNull, 4'd0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", {62'b0, ring.rspDriveRing, rspBusy}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    passSlot("rst_token_after", 32'h0000_0000, tTok, 4'd0, 1'b0);
    passSlot("rst_idle", 32'h0000_0999, tNull, 4'd0, 1'b0);
`ifdef RSP_DROP_COUNT_EN
    check("rst_dropCount", {56'b0, dropCount}, 64'd0);
`endif

    // Randomized messages against a transaction-level model.
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  core;
      logic [3:0]  src;
      logic [3:0]  typ;
      logic [5:0]  len;
      logic [7:0]  cnt;
      logic [31:0] expSum;
      logic [31:0] tokData;
      logic [31:0] pay[$];
      int          gap;

      core      = 4'($urandom_range(0, 15));
      src       = 4'($urandom_range(0, 15));
      typ       = 4'($urandom_range(0, 15));
      len       = 6'($urandom_range(0, 4));
      cnt       = 8'($urandom_range(0, 3));
      gap       = $urandom_range(0, 2);
      whichCore = core;
      pay.delete();
      expSum = 32'd0;
      for (int i = 0; i < int'(len); i++) begin
        pay.push_back($urandom);
        expSum = expSum + pay[i];
      end

      nullSlot($sformatf("rnd%0d_hdr", n), hdr(src, typ, len), 1'b0);
      foreach (pay[i]) nullSlot($sformatf("rnd%0d_pay%0d", n, i), pay[i], 1'b1);
      for (int g = 0; g < gap; g++) begin
        passSlot($sformatf("rnd%0d_gap%0d", n, g), $urandom, tMsg,
                 core + 4'($urandom_range(1, 15)), 1'b1);
      end
      tokData = ($urandom & 32'hFFFF_FF00) | {24'b0, cnt};
      tokenSlot($sformatf("rnd%0d_token", n), tokData);
      for (int k = 0; k < int'(cnt); k++) begin
        passSlot($sformatf("rnd%0d_train%0d", n, k), $urandom, tNull, 4'd0, 1'b1);
      end
      replySlot($sformatf("rnd%0d_rhdr", n), hdr(core, typ, 6'd1), src);
      replySlot($sformatf("rnd%0d_sum", n), expSum, src);
      passSlot($sformatf("rnd%0d_idle", n), $urandom, tNull, 4'd0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/ring_checksum_responder.md
# ring_checksum_responder

- Ring-attached responder core: the far end of the messenger protocol.
- Accepts messages addressed to its core and removes them from the ring.
- Sums each message's payload into a 32-bit checksum.
- Answers every accepted message with a single-payload-word reply to the sender: grabs a Token, waits out the train, then transmits.
- Sits on the ring alongside the per-core messengers and drives the ring only through its own output mux.

## Interface
Parameters:
- none (core number comes from `whichCore`)

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high
- `whichCore`  in  4  this responder's ring address
- `RingIn`  in  32  ring data slot
- `SlotTypeIn`  in  4  slot type (Token=1, Null=7, Message=8)
- `SrcDestIn`  in  4  slot destination core
- `rspRingOut`  out  32  ring data to drive
- `rspSlotTypeOut`  out  4  slot type to drive
- `rspSrcDestOut`  out  4  destination to drive
- `rspDriveRing`  out  1  high when the outputs replace the ring slot
- `rspBusy`  out  1  high whenever state ≠ idle
- `dropCount`  out  8  saturating count of dropped requests (present only with `RSP_DROP_COUNT_EN`)

## Operation
Slot formats:
- Header slot: `{18'b0, src[13:10], type[9:6], len[5:0]}`.
- `mine` = (SlotTypeIn==Message) & (SrcDestIn==whichCore).
- Every `mine` slot is driven back as Null, with RingIn and SrcDestIn passed through (rspDriveRing=1).

Receive path:
- 6-bit `inLen` tracks the remaining payload of the current incoming message.
- First word: `mine` & inLen==0. Load inLen←len; capture src, type into srcReg, typeReg; clear `sum`.
- Payload words (inLen≠0): inLen decrements each cycle; sum ← sum + RingIn, mod 2^32, carry discarded.
- A message is accepted only if its header arrives in state idle.
- A header arriving in any other state is dropped:
  - its slots are still nulled and inLen still tracks its payload;
  - sum, srcReg and typeReg are untouched;
  - dropCount increments, saturating at 255.

States (4-bit):
- idle:
  - on an accepted header with len≠0 → rxPay;
  - on an accepted header with len==0 → waitToken (sum=0).
- rxPay: when inLen==1 (last word) → waitToken.
- waitToken:
  - on SlotTypeIn==Token, drive rspRingOut=RingIn+2 (full 32-bit add: header + 1 payload word).
  - If RingIn[7:0]==0 → sendHdr; else burst←RingIn[7:0] → waitN.
- waitN: burst←burst−1; when burst==1 → sendHdr.
- sendHdr:
  - drive Message, SrcDest=srcReg, data `{18'b0, whichCore, typeReg, 6'd1}`;
  - → sendPay.
- sendPay: drive Message, SrcDest=srcReg, data=sum; → idle.

Output priority:
- sendHdr/sendPay output overrides everything, including a `mine` input in the same slot.
- Next priority: waitToken&Token.
- Then: `mine`→Null.
- Otherwise rspDriveRing=0 and outputs echo the inputs.

Self-addressed case: src==whichCore is handled like any other source (the reply is addressed to itself).

## Timing
Reset values:
- state=idle, inLen=0, sum=0, burst=0, dropCount=0.
- rspDriveRing=0, rspBusy=0.
- Data outputs echo the inputs.

Latencies:
- Header at cycle 0 with len=N: payload at cycles 1..N, state=waitToken at cycle N+1 (cycle 1 if N=0).
- Token seen with train count 0 at cycle T: header at T+1, checksum at T+2, idle at T+3.
- Token with train count k≠0 at cycle T: header at T+k+1.

Boundary behaviour:
- inLen is independent of state.
- A header presented while inLen≠0 is treated as payload (protocol forbids it; no check is made).
- A header arriving on the same cycle sendPay exits to idle is dropped; acceptance uses the registered state.
- Reset asserted mid-send: outputs return to passthrough immediately. Reset is asynchronous and the reply is abandoned.

## Configuration
`RSP_DROP_COUNT_EN`:
- Defined: `dropCount` port and its saturating 8-bit counter exist.
- Undefined: the port and counter are absent. Dropped messages are still nulled and skipped, with no other change in behaviour.

## Test plan
- whichCore=6; header 0x00000D42 (src 3, type 5, len 2), then 0x10, 0x20; Token with RingIn=0 → rspRingOut=2 on the Token; next slot Message/dest 3/0x00001941; next Message/dest 3/0x30; rspBusy low after.
- Zero-length header 0x00000A00 (src 2, type 8) → reply header 0x00001A01 then payload 0x00000000, dest 2.
- Token with RingIn=3 → rspRingOut=5; header emitted exactly 4 cycles after the Token; slots in between pass through with rspDriveRing=0.
- Payload 0xFFFFFFFF, 0x00000002 → checksum 0x00000001 (wraparound).
- Second header arriving during waitN → both messages' slots nulled; reply carries the first message's checksum; dropCount=1; 256 drops → dropCount holds at 255.
- Reset pulsed during waitN → rspDriveRing=0 and rspBusy=0 within the same cycle; the following Token passes unmodified.
